// File: rtl/inst_assembler_if.sv
// inst_assembler_if: field-tuple input handshake plus instruction-memory write port.
interface inst_assembler_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [5:0]              in_opcode;
    logic [4:0]              in_rs;
    logic [4:0]              in_rt;
    logic [15:0]             in_imm;
    logic                    wr_en;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_addr;
    logic [31:0]             wr_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    halted;

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_imm, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, count, halted
    );

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_imm, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, count, halted
    );
endinterface

// File: rtl/inst_assembler.sv
// inst_assembler: packs I-type fields into 32-bit words, buffers them in a FIFO and writes them to memory.
// Define INST_ASM_HALT_ON_WRAP_EN to stop after the last address instead of wrapping to 0.
module inst_assembler #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    inst_assembler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              halted, push, pop, flush, not_empty;

    assign flush     = !rst_n || clr;
    assign not_empty = count_q != '0;
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = bus.wr_en && bus.wr_ready;

    assign bus.in_ready = (count_q < CW'(DEPTH)) && !halted;
    assign bus.wr_en    = not_empty && !halted;
    assign bus.wr_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.wr_addr  = addr_q;
    assign bus.count    = count_q;
    assign bus.halted   = halted;

`ifdef INST_ASM_HALT_ON_WRAP_EN
    localparam logic [ADDR_W-1:0] LAST = ~ADDR_W'(3);

    typedef enum logic {RUN, HALT} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (flush) state_q <= RUN;
        else       state_q <= state_d;
    end

    // The pop of the final address is the last write this block will ever make.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && pop && addr_q == LAST) state_d = HALT;
    end

    assign halted = state_q == HALT;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        addr_d   = pop ? addr_q + ADDR_W'(4) : addr_q;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    // Storage is never cleared; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!flush && push) mem_q[wr_ptr_q] <= {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm};
    end
endmodule

// File: tb/tb_inst_assembler.sv
// tb_inst_assembler: table-driven encode checks plus directed backpressure, streaming, wrap/halt and reset sequences.
module tb_inst_assembler;
    logic        clk = 0, rst_n = 0, clr = 0, in_valid = 0, wr_ready = 0;
    logic [5:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0;
    logic [15:0] imm = '0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;
    vec_t vt[7];

    inst_assembler_if #(.DEPTH(4), .ADDR_W(8)) bus();
    inst_assembler_if #(.DEPTH(4), .ADDR_W(4)) bus4();

    assign bus.in_valid   = in_valid;
    assign bus.in_opcode  = op;
    assign bus.in_rs      = rs;
    assign bus.in_rt      = rt;
    assign bus.in_imm     = imm;
    assign bus.wr_ready   = wr_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.in_opcode = op;
    assign bus4.in_rs     = rs;
    assign bus4.in_rt     = rt;
    assign bus4.in_imm    = imm;
    assign bus4.wr_ready  = wr_ready;

    inst_assembler #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u_dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));
    inst_assembler #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) u_wrap (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w);
        {op, rs, rt, imm} = w;
    endtask

    function automatic logic [31:0] sw(input int k);
        return 32'hA500_0000 ^ 32'(k * 32'h0123_4567);
    endfunction

    task automatic do_clr();
        clr = 1;
        step();
        clr = 0;
    endtask

    initial begin
        vt[0] = '{6'h08, 5'd8,  5'd9,  16'h0005, 32'h2109_0005};
        vt[1] = '{6'h00, 5'd0,  5'd0,  16'h0000, 32'h0000_0000};
        vt[2] = '{6'h3F, 5'd31, 5'd31, 16'hFFFF, 32'hFFFF_FFFF};
        vt[3] = '{6'h23, 5'd1,  5'd2,  16'h0010, 32'h8C22_0010};
        vt[4] = '{6'h2B, 5'd29, 5'd31, 16'hFFFC, 32'hAFBF_FFFC};
        vt[5] = '{6'h00, 5'd1,  5'd2,  16'h1820, 32'h0022_1820};
        vt[6] = '{6'h20, 5'd16, 5'd0,  16'h8000, 32'h8200_8000};

        // reset state
        repeat (2) step();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_addr", 32'(bus.wr_addr), 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        rst_n = 1;
        step();

        // encode table, streaming with wr_ready high
        wr_ready = 1;
        for (int i = 0; i < 7; i++) begin
            op = vt[i].op; rs = vt[i].rs; rt = vt[i].rt; imm = vt[i].imm;
            in_valid = 1;
            step();
            chk("enc_wr_en", 32'(bus.wr_en), 1);
            chk("enc_data", bus.wr_data, vt[i].word);
            chk("enc_addr", 32'(bus.wr_addr), 32'(i * 4));
            chk("enc_count", 32'(bus.count), 1);
        end
        in_valid = 0;
        step();
        chk("enc_idle_wr_en", 32'(bus.wr_en), 0);
        chk("enc_idle_addr", 32'(bus.wr_addr), 32'h1C);
        chk("enc_idle_data", bus.wr_data, 0);

        // backpressure: 5 pushes, 4 accepted, then drain
        do_clr();
        chk("clr_addr", 32'(bus.wr_addr), 0);
        chk("clr_count", 32'(bus.count), 0);
        wr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            op = vt[k].op; rs = vt[k].rs; rt = vt[k].rt; imm = vt[k].imm;
            in_valid = 1;
            chk("bp_in_ready", 32'(bus.in_ready), (k < 4) ? 1 : 0);
            step();
        end
        in_valid = 0;
        chk("bp_count", 32'(bus.count), 4);
        chk("bp_hold_data", bus.wr_data, vt[0].word);
        step();
        chk("bp_hold_data2", bus.wr_data, vt[0].word);
        chk("bp_hold_addr", 32'(bus.wr_addr), 0);
        wr_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_data", bus.wr_data, vt[k].word);
            chk("bp_drain_addr", 32'(bus.wr_addr), 32'(k * 4));
            step();
        end
        chk("bp_empty_wr_en", 32'(bus.wr_en), 0);
        chk("bp_empty_count", 32'(bus.count), 0);

        // simultaneous push/pop at count 2 across pointer wrap
        do_clr();
        wr_ready = 0;
        in_valid = 1;
        for (int k = 0; k < 2; k++) begin
            drive(sw(k));
            step();
        end
        chk("pp_count_fill", 32'(bus.count), 2);
        wr_ready = 1;
        for (int k = 2; k < 12; k++) begin
            drive(sw(k));
            chk("pp_head", bus.wr_data, sw(k - 2));
            step();
            chk("pp_count", 32'(bus.count), 2);
        end
        in_valid = 0;
        for (int k = 10; k < 12; k++) begin
            chk("pp_tail", bus.wr_data, sw(k));
            step();
        end
        chk("pp_end_count", 32'(bus.count), 0);
        chk("pp_end_addr", 32'(bus.wr_addr), 32'h30);

        // address wrap / halt on the 4-bit address instance
        do_clr();
        wr_ready = 1;
        in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            drive(sw(100 + k));
            step();
            chk("wrap_addr", 32'(bus4.wr_addr), 32'(k * 4));
            chk("wrap_data", bus4.wr_data, sw(100 + k));
        end
        drive(sw(104));
        step();
`ifdef INST_ASM_HALT_ON_WRAP_EN
        chk("halt_halted", 32'(bus4.halted), 1);
        chk("halt_in_ready", 32'(bus4.in_ready), 0);
        chk("halt_wr_en", 32'(bus4.wr_en), 0);
        chk("halt_count", 32'(bus4.count), 1);
        drive(sw(105));
        step();
        chk("halt_refuse", 32'(bus4.count), 1);
        in_valid = 0;
        do_clr();
        chk("halt_clr_halted", 32'(bus4.halted), 0);
        chk("halt_clr_count", 32'(bus4.count), 0);
        drive(sw(106));
        in_valid = 1;
        step();
        in_valid = 0;
        chk("halt_restart_addr", 32'(bus4.wr_addr), 0);
        chk("halt_restart_en", 32'(bus4.wr_en), 1);
        step();
`else
        chk("wrap_to_zero", 32'(bus4.wr_addr), 0);
        chk("wrap_data4", bus4.wr_data, sw(104));
        chk("wrap_halted", 32'(bus4.halted), 0);
        in_valid = 0;
        step();
        chk("wrap_after_addr", 32'(bus4.wr_addr), 4);
        chk("wrap_after_en", 32'(bus4.wr_en), 0);
`endif

        // reset mid-operation with 3 buffered words
        do_clr();
        wr_ready = 0;
        in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            drive(sw(200 + k));
            step();
        end
        in_valid = 0;
        chk("mr_count3", 32'(bus.count), 3);
        rst_n = 0;
        step();
        chk("mr_count", 32'(bus.count), 0);
        chk("mr_wr_en", 32'(bus.wr_en), 0);
        chk("mr_addr", 32'(bus.wr_addr), 0);
        chk("mr_data", bus.wr_data, 0);
        rst_n = 1;
        drive(sw(300));
        in_valid = 1;
        wr_ready = 1;
        step();
        in_valid = 0;
        chk("mr_first_addr", 32'(bus.wr_addr), 0);
        chk("mr_first_data", bus.wr_data, sw(300));
        step();
        chk("mr_next_addr", 32'(bus.wr_addr), 4);
        chk("mr_next_en", 32'(bus.wr_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
